// File: rtl/dqn_pkg.sv
// Shared DQN datapath constants: Q-table geometry and
// the requester slots that contend for the Q-table RAM.
package dqn_pkg;

    localparam int DQN_AW   = 8;
    localparam int DQN_DW   = 16;
    localparam int NREQ_DQN = 3;

    typedef enum logic [1:0] {
        REQ_ACT = 2'd0,
        REQ_TGT = 2'd1,
        REQ_UPD = 2'd2
    } req_id_e;

endpackage

// File: rtl/qtab_port_arbiter_rr_pick.sv
// Rotating priority encoder: first request at or above ptr
// (mod N) wins, returned as one-hot grant plus index.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = PW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qtab_port_arbiter.sv
// Round-robin arbiter sharing the single-port Q-table RAM.
// Define ARB_LOCK_EN to add the lock port (bounded ownership).
module qtab_port_arbiter
    import dqn_pkg::*;
#(
    parameter int NREQ   = NREQ_DQN,
    parameter int AW     = DQN_AW,
    parameter int DW     = DQN_DW,
    parameter int RD_LAT = 1
`ifdef ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 9
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    localparam int PW = $clog2(NREQ);
    localparam int D  = 1 + RD_LAT;

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] req_eff;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   gidx;
    logic            pick_any;
    logic            grant;
    logic [D-1:0]    pv;
    logic [PW-1:0]   pid [D];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
    endfunction

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req (req_eff),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (gidx),
        .any (pick_any)
    );

    assign grant = pick_any & ~rst;
    assign gnt   = rst ? '0 : pick_gnt;
    assign rdata = mem_rdata;
    assign busy  = |pv;

    always_comb begin
        rvalid = '0;
        if (pv[D-1]) rvalid[pid[D-1]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pv        <= '0;
            for (int k = 0; k < D; k++) pid[k] <= '0;
        end else begin
            mem_en <= grant;
            if (grant) begin
                mem_we    <= we[gidx];
                mem_addr  <= addr[int'(gidx)*AW +: AW];
                mem_wdata <= wdata[int'(gidx)*DW +: DW];
            end else begin
                mem_we <= 1'b0;
            end
            // Only reads travel down the return pipeline
            pv     <= {pv[D-2:0], grant & ~we[gidx]};
            pid[0] <= gidx;
            for (int k = 1; k < D; k++) pid[k] <= pid[k-1];
        end
    end

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic          owner_v;
    logic [PW-1:0] owner_id;
    logic [CW-1:0] lock_cnt;

    assign req_eff = owner_v ? (req & (NREQ'(1) << owner_id)) : req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            owner_v  <= 1'b0;
            owner_id <= '0;
            lock_cnt <= '0;
        end else if (owner_v) begin
            if (grant && lock[owner_id] && lock_cnt < CW'(MAX_LOCK - 1)) begin
                lock_cnt <= lock_cnt + CW'(1);
            end else begin
                owner_v  <= 1'b0;
                lock_cnt <= '0;
                ptr      <= nxt(owner_id);
            end
        end else if (grant) begin
            ptr <= nxt(gidx);
            if (lock[gidx] && MAX_LOCK > 1) begin
                owner_v  <= 1'b1;
                owner_id <= gidx;
                lock_cnt <= CW'(1);
            end
        end
    end
`else
    assign req_eff = req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= nxt(gidx);
        end
    end
`endif

endmodule

// File: tb/tb_qtab_port_arbiter.sv
// Scoreboard bench for qtab_port_arbiter: RD_LAT=1 and RD_LAT=3
// instances share stimulus, each with its own RAM model.
module tb_qtab_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int ML = 9;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          due;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;

    logic [N-1:0]  gnt1, gnt3, rv1, rv3;
    logic [DW-1:0] rd1, rd3, mwd1, mwd3, mrd1, mrd3;
    logic [AW-1:0] ma1, ma3;
    logic          en1, en3, mwe1, mwe3, busy1, busy3;

    qtab_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .wdata(wdata),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt1), .rvalid(rv1), .rdata(rd1), .mem_en(en1),
        .mem_we(mwe1), .mem_addr(ma1), .mem_wdata(mwd1),
        .mem_rdata(mrd1), .busy(busy1)
    );

    qtab_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .wdata(wdata),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt3), .rvalid(rv3), .rdata(rd3), .mem_en(en3),
        .mem_we(mwe3), .mem_addr(ma3), .mem_wdata(mwd3),
        .mem_rdata(mrd3), .busy(busy3)
    );

    // Write-first single-port RAM models
    logic [DW-1:0] ram1 [256];
    logic [DW-1:0] ram3 [256];
    logic [DW-1:0] rp1;
    logic [DW-1:0] rp3 [3];

    always @(posedge clk) begin
        if (en1) begin
            if (mwe1) ram1[ma1] <= mwd1;
            rp1 <= mwe1 ? mwd1 : ram1[ma1];
        end
        if (en3) begin
            if (mwe3) ram3[ma3] <= mwd3;
            rp3[0] <= mwe3 ? mwd3 : ram3[ma3];
        end
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign mrd1 = rp1;
    assign mrd3 = rp3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_val(input int a);
        if (a == 'h2A) return 16'h1234;
        return 16'(a * 'h0101) ^ 16'h5A5A;
    endfunction

    // Reference model state
    logic [15:0] mm [256];
    rd_t         q1 [$];
    rd_t         q3 [$];
    int          mptr = 0, own = 0, lcnt = 0, last_g = -1;
    bit          own_v = 0, exp_en = 0;
    logic        exp_we;
    logic [7:0]  exp_a;
    logic [15:0] exp_d;

    bit          pend [N], sticky [N];
    logic        pwe [N];
    logic [7:0]  paddr [N];
    logic [15:0] pwd [N];

    logic [N-1:0] seen_g, seen_rv1, seen_rv3;
    logic [15:0]  seen_rd1;
    logic         seen_en, seen_we, seen_b1, seen_b3;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic issue(input int i, input logic w, input logic [7:0] a,
                         input logic [15:0] d);
        pend[i]  = 1;
        pwe[i]   = w;
        paddr[i] = a;
        pwd[i]   = d;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]            = pend[i];
            we[i]             = pwe[i];
            addr[i*AW +: AW]  = paddr[i];
            wdata[i*DW +: DW] = pwd[i];
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] lk, eg, erv;
        int g;
        seen_g   = gnt1;
        seen_en  = en1;
        seen_we  = mwe1;
        seen_b1  = busy1;
        seen_b3  = busy3;
        seen_rv1 = rv1;
        seen_rv3 = rv3;
        seen_rd1 = rd1;
`ifdef ARB_LOCK_EN
        lk = lock;
`else
        lk = '0;
`endif
        if (rst) begin
            chk("rst_gnt", {29'd0, gnt1 | gnt3}, 0);
            chk("rst_en", {31'd0, en1 | en3}, 0);
            chk("rst_busy", {31'd0, busy1 | busy3}, 0);
            chk("rst_rvalid", {29'd0, rv1 | rv3}, 0);
            mptr = 0; own_v = 0; lcnt = 0; exp_en = 0; last_g = -1;
            q1.delete();
            q3.delete();
            return;
        end
        g = own_v ? (req[own] ? own : -1) : pick(req, mptr);
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt1", {29'd0, gnt1}, {29'd0, eg});
        chk("gnt3", {29'd0, gnt3}, {29'd0, eg});
        chk("mem_en1", {31'd0, en1}, {31'd0, exp_en});
        chk("mem_en3", {31'd0, en3}, {31'd0, exp_en});
        if (exp_en) begin
            chk("mem_we", {31'd0, mwe1}, {31'd0, exp_we});
            chk("mem_addr", {24'd0, ma1}, {24'd0, exp_a});
            chk("mem_addr3", {24'd0, ma3}, {24'd0, exp_a});
            if (exp_we) chk("mem_wdata", {16'd0, mwd1}, {16'd0, exp_d});
        end
        chk("busy1", {31'd0, busy1}, {31'd0, q1.size() != 0});
        chk("busy3", {31'd0, busy3}, {31'd0, q3.size() != 0});
        erv = '0;
        if (q1.size() != 0 && q1[0].due == cyc) erv[q1[0].id] = 1'b1;
        chk("rvalid1", {29'd0, rv1}, {29'd0, erv});
        if (erv != 0) begin
            chk("rdata1", {16'd0, rd1}, {16'd0, q1[0].data});
            void'(q1.pop_front());
        end
        erv = '0;
        if (q3.size() != 0 && q3[0].due == cyc) erv[q3[0].id] = 1'b1;
        chk("rvalid3", {29'd0, rv3}, {29'd0, erv});
        if (erv != 0) begin
            chk("rdata3", {16'd0, rd3}, {16'd0, q3[0].data});
            void'(q3.pop_front());
        end
        exp_en = (g >= 0);
        last_g = g;
        if (g >= 0) begin
            exp_we = pwe[g];
            exp_a  = paddr[g];
            exp_d  = pwd[g];
            if (pwe[g]) begin
                mm[paddr[g]] = pwd[g];
            end else begin
                q1.push_back('{g, mm[paddr[g]], cyc + 2});
                q3.push_back('{g, mm[paddr[g]], cyc + 4});
            end
        end
        if (own_v) begin
            if (g >= 0 && lk[own] && lcnt + 1 < ML) begin
                lcnt++;
            end else begin
                own_v = 0;
                mptr  = (own + 1) % N;
            end
        end else if (g >= 0) begin
            mptr = (g + 1) % N;
            if (lk[g]) begin
                own_v = 1;
                own   = g;
                lcnt  = 1;
            end
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (last_g >= 0 && !sticky[last_g]) pend[last_g] = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pend[i]   = 0;
            sticky[i] = 0;
        end
    endtask

    logic [N-1:0] gseq [13];

    initial begin
        for (int a = 0; a < 256; a++) begin
            ram1[a] <= init_val(a);
            ram3[a] <= init_val(a);
            mm[a]    = init_val(a);
        end
        lock = '0;
        for (int i = 0; i < N; i++) begin
            issue(i, 1'b0, 8'(8'h40 + i), 16'h0);
            sticky[i] = 1;
        end
        tick();
        tick();
        chk("rst_hold_gnt", {29'd0, seen_g}, 0);
        chk("rst_hold_en", {31'd0, seen_en}, 0);
        rst = 1'b0;
        tick(); chk("rr0", {29'd0, seen_g}, 32'b001);
        tick(); chk("rr1", {29'd0, seen_g}, 32'b010);
        tick(); chk("rr2", {29'd0, seen_g}, 32'b100);
        tick(); chk("rr3", {29'd0, seen_g}, 32'b001);
        clear_reqs();
        idle(6);

        issue(1, 1'b0, 8'h2A, 16'h0);
        tick(); chk("rd_gnt", {29'd0, seen_g}, 32'b010);
        tick(); chk("rd_en", {31'd0, seen_en}, 1);
        chk("rd_we", {31'd0, seen_we}, 0);
        chk("rd_busy_t1", {31'd0, seen_b1}, 1);
        tick(); chk("rd_rv", {29'd0, seen_rv1}, 32'b010);
        chk("rd_data", {16'd0, seen_rd1}, 32'h1234);
        chk("rd_busy_t2", {31'd0, seen_b1}, 1);
        idle(4);

        issue(2, 1'b1, 8'h05, 16'h00FF);
        issue(0, 1'b0, 8'h05, 16'h0);
        tick(); chk("raw_wr_gnt", {29'd0, seen_g}, 32'b100);
        tick(); chk("raw_rd_gnt", {29'd0, seen_g}, 32'b001);
        tick();
        tick(); chk("raw_rv", {29'd0, seen_rv1}, 32'b001);
        chk("raw_data", {16'd0, seen_rd1}, 32'h00FF);
        idle(6);

        issue(2, 1'b1, 8'h10, 16'hBEEF);
        tick();
        issue(0, 1'b0, 8'h2A, 16'h0);
        issue(1, 1'b0, 8'h07, 16'h0);
        tick(); chk("b2b_g0", {29'd0, seen_g}, 32'b001);
        tick(); chk("b2b_g1", {29'd0, seen_g}, 32'b010);
        tick();
        tick();
        tick(); chk("b2b_rv0", {29'd0, seen_rv3}, 32'b001);
        tick(); chk("b2b_rv1", {29'd0, seen_rv3}, 32'b010);
        idle(4);

        issue(0, 1'b0, 8'h2A, 16'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_busy1", {31'd0, seen_b1}, 0);
        chk("mid_busy3", {31'd0, seen_b3}, 0);
        rst = 1'b0;
        idle(5);
        issue(0, 1'b0, 8'h01, 16'h0);
        issue(2, 1'b0, 8'h02, 16'h0);
        tick(); chk("rst_ptr", {29'd0, seen_g}, 32'b001);
        idle(6);

`ifdef ARB_LOCK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            issue(i, 1'b1, 8'(8'h60 + i), 16'(i));
            sticky[i] = 1;
        end
        lock = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            gseq[k] = seen_g;
        end
        for (int k = 1; k <= ML; k++) chk("lock_own", {29'd0, gseq[k]}, 32'b001);
        chk("lock_rel1", {29'd0, gseq[10]}, 32'b010);
        chk("lock_rel2", {29'd0, gseq[11]}, 32'b100);
        lock = '0;
        clear_reqs();
        idle(6);
`endif

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    issue(i, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), 16'($urandom));
`ifdef ARB_LOCK_EN
            lock = 3'($urandom);
`endif
            tick();
        end
        clear_reqs();
        lock = '0;
        for (int k = 0; k < 10; k++)
            if (q1.size() != 0 || q3.size() != 0) tick();
        chk("drain1", q1.size(), 0);
        chk("drain3", q3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
